seq_divider: RTL

- Sequential restoring shift-subtract divider; the inverse of the team's sequential shift-add multiplier.
- Divides a 2*DATAWIDTH-bit dividend (e.g. a multiplier product) by a DATAWIDTH-bit divisor, resolving one quotient bit per clock.
- Sits beside the multiplier in the arithmetic datapath.
- Uses an explicit start/busy/done handshake instead of a free-running counter.

---
 rtl/seq_divider_pkg.sv | 18 +
 rtl/seq_divider_div_step.sv | 31 +++
 rtl/seq_divider.sv | 139 +++++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared arithmetic definitions for the sequential multiplier/divider pair.
//   DATAWIDTH : default operand width (divisor width; dividend/quotient are 2x)
//   DW2       : double width (dividend, quotient, product)
//   CNTW      : iteration counter width, sized to hold 0..DW2
//   div_state_t : divider FSM state encoding
package seq_divider_pkg;

   localparam int DATAWIDTH = 14;
   localparam int DW2       = 2 * DATAWIDTH;
   localparam int CNTW      = $clog2(DW2 + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: compare the shifted partial remainder against
// the divisor and subtract when it fits.
//   part_rem : DATAWIDTH+1-bit shifted partial remainder
//   divisor  : DATAWIDTH-bit divisor
//   next_rem : DATAWIDTH-bit partial remainder after the step
//   q_bit    : quotient bit resolved by this step
module seq_divider_div_step
   import seq_divider_pkg::*;
#(
   parameter int DW = seq_divider_pkg::DATAWIDTH
) (
   input  logic [DW:0]   part_rem,
   input  logic [DW-1:0] divisor,
   output logic [DW-1:0] next_rem,
   output logic          q_bit
);

   logic          fits;
   logic [DW-1:0] diff;

   assign fits = (part_rem >= {1'b0, divisor});

   // The incoming remainder is always < 2*divisor, so whenever the divisor
   // fits the true difference is < divisor and the modulo-2^DW subtract of
   // the low bits is exact; the top bit only matters for the compare.
   assign diff = part_rem[DW-1:0] - divisor;

   assign q_bit    = fits;
   assign next_rem = fits ? diff : part_rem[DW-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring shift-subtract divider, one quotient bit per clock.
// Divides a 2*DATAWIDTH-bit dividend by a DATAWIDTH-bit divisor.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request, only sampled in IDLE
//   dividend    : captured on accept
//   divisor     : captured on accept
//   busy        : high while iterating
//   done        : one-cycle pulse, results valid
//   quotient    : registered quotient (all ones on divide by zero)
//   remainder   : registered remainder (0 on divide by zero)
//   div_by_zero : registered flag, valid with done
//
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// CALC  | one shift/compare/subtract per cycle, 2*DATAWIDTH cycles
// DONE  | results valid, done pulse, back to IDLE
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int DATAWIDTH = seq_divider_pkg::DATAWIDTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [2*DATAWIDTH-1:0]   dividend,
   input  logic [DATAWIDTH-1:0]     divisor,
   output logic                     busy,
   output logic                     done,
   output logic [2*DATAWIDTH-1:0]   quotient,
   output logic [DATAWIDTH-1:0]     remainder,
   output logic                     div_by_zero
);

   localparam int QW = 2 * DATAWIDTH;
   localparam int CW = $clog2(QW + 1);

   div_state_t           state_q;
   div_state_t           state_d;
   logic [CW-1:0]        cnt_q;
   logic [DATAWIDTH-1:0] rem_q;
   logic [QW-1:0]        sr_q;
   logic [DATAWIDTH-1:0] dvs_q;

   logic                 accept;
   logic                 last_iter;
   logic                 dvs_zero;
   logic [DATAWIDTH:0]   part_rem;
   logic [DATAWIDTH-1:0] step_rem;
   logic                 step_q;
   logic [QW-1:0]        sr_next;

   assign dvs_zero = (divisor == '0);

   // Dividend bits enter the remainder MSB-first while quotient bits fill
   // the vacated LSBs, so sr_q ends up holding the quotient.
   assign part_rem = {rem_q, sr_q[QW-1]};
   assign sr_next  = {sr_q[QW-2:0], step_q};

   seq_divider_div_step #(
      .DW (DATAWIDTH)
   ) u_div_step (
      .part_rem (part_rem),
      .divisor  (dvs_q),
      .next_rem (step_rem),
      .q_bit    (step_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      last_iter = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = dvs_zero ? DONE : CALC;
            end
         end
         CALC: begin
            busy = 1'b1;
            if (cnt_q == CW'(QW - 1)) begin
               last_iter = 1'b1;
               state_d   = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         rem_q       <= '0;
         sr_q        <= '0;
         dvs_q       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         cnt_q <= '0;
         rem_q <= '0;
         sr_q  <= dividend;
         dvs_q <= divisor;
         if (dvs_zero) begin
            quotient    <= '1;
            remainder   <= '0;
            div_by_zero <= 1'b1;
         end
      end else if (state_q == CALC) begin
         rem_q <= step_rem;
         sr_q  <= sr_next;
         if (last_iter) begin
            cnt_q       <= '0;
            quotient    <= sr_next;
            remainder   <= step_rem;
            div_by_zero <= 1'b0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

endmodule
